// File: rtl/grf_wport_arbiter_pkg.sv
// grf_wport_arbiter_pkg: shared widths and the write-request record for the GRF write port.
package grf_wport_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic we;
    logic [REG_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: power-of-2 FIFO of write requests with registered full/empty flags.
module grf_wb_fifo
  import grf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t push_req,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, full_d, empty_q, empty_d, do_push, do_pop;
  wb_req_t mem_q [DEPTH];
  always_comb begin
    do_push = push && !full_q;
    do_pop = pop && !empty_q;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d = cnt_d == (AW+1)'(DEPTH);
    empty_d = cnt_d == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_req;
  end
  assign head = mem_q[rd_q];
  assign full = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter: shares the GRF write port between W-stage writeback and buffered async results,
// with a starvation hold and a pending-write scoreboard for D-stage hazard stalls.
module grf_wport_arbiter
  import grf_wport_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_we,
  input  logic [REG_W-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_addr,
  input  logic [REG_W-1:0]  q1_addr,
  input  logic [REG_W-1:0]  q2_addr,
  input  logic [REG_W-1:0]  q3_addr,
  output logic              q_stall,
  output logic              pipe_hold,
  output logic              grf_we,
  output logic [REG_W-1:0]  grf_a3,
  output logic [DATA_W-1:0] grf_wd
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_req_t w_req, a_req, head, grant;
  logic fifo_full, fifo_empty, w_win, pop, starving, hold_q, hold_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  assign w_req = '{we: w_we, addr: w_addr, data: w_data};
  assign a_req = '{we: 1'b1, addr: a_addr, data: a_data};
  assign a_ready = !fifo_full;
  grf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(a_valid && a_ready),
    .pop(pop),
    .push_req(a_req),
    .head(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    w_win = !hold_q && w_we;
    pop = !w_win && !fifo_empty;
    grant = w_win ? w_req : (pop ? head : '0);
    grf_we = rst && grant.we && grant.addr != '0;
    grf_a3 = grant.addr;
    grf_wd = grant.data;
    starving = !fifo_empty && !pop;
    starve_d = !starving ? '0 : (starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + SW'(1));
    hold_d = starving && starve_q == SW'(STARVE_LIMIT - 1);
    pend_d = pend_q;
    // Clear before set so a same-cycle reissue of the popped destination stays pending.
    if (pop) pend_d[head.addr] = 1'b0;
    if (iss_valid) pend_d[iss_addr] = 1'b1;
    pend_d[0] = 1'b0;
    q_stall = pend_q[q1_addr] || pend_q[q2_addr] || pend_q[q3_addr];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
      hold_q <= 1'b0;
      pend_q <= '0;
    end else begin
      starve_q <= starve_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
    end
  end
  assign pipe_hold = hold_q;
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// tb_grf_wport_arbiter: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_grf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clk = 0, rst = 0;
  logic w_we = 0, a_valid = 0, iss_valid = 0;
  logic [4:0] w_addr = 0, a_addr = 0, iss_addr = 0, q1_addr = 0, q2_addr = 0, q3_addr = 0;
  logic [31:0] w_data = 0, a_data = 0;
  logic a_ready, q_stall, pipe_hold, grf_we;
  logic [4:0] grf_a3;
  logic [31:0] grf_wd;
  int vectors = 0, errs = 0;

  typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
  ent_t mq[$];
  bit [31:0] mpend;
  int mstarve;
  bit mhold;
  bit e_we, e_ready, e_stall;
  logic [4:0] e_a3;
  logic [31:0] e_wd;

  always #5 clk = ~clk;

  grf_wport_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .q1_addr(q1_addr), .q2_addr(q2_addr),
    .q3_addr(q3_addr), .q_stall(q_stall), .pipe_hold(pipe_hold), .grf_we(grf_we),
    .grf_a3(grf_a3), .grf_wd(grf_wd)
  );

  function automatic void predict();
    bit wg, pp;
    wg = !mhold && w_we;
    pp = !wg && mq.size() > 0;
    e_a3 = wg ? w_addr : (pp ? mq[0].a : 5'd0);
    e_wd = wg ? w_data : (pp ? mq[0].d : 32'd0);
    e_we = rst && (wg || pp) && e_a3 != 0;
    e_ready = mq.size() < DEPTH;
    e_stall = mpend[q1_addr] | mpend[q2_addr] | mpend[q3_addr];
  endfunction

  always @(posedge clk) begin : model
    int n;
    bit wg, pp, st, acc;
    n = mq.size();
    wg = !mhold && w_we;
    pp = !wg && n > 0;
    st = n > 0 && !pp;
    acc = a_valid && n < DEPTH;
    if (!rst) begin
      mq.delete();
      mpend = 0;
      mstarve = 0;
      mhold = 0;
    end else begin
      mhold = st && mstarve == LIMIT - 1;
      mstarve = st ? (mstarve < LIMIT ? mstarve + 1 : mstarve) : 0;
      if (pp) begin
        mpend[mq[0].a] = 0;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back('{a_addr, a_data});
      if (iss_valid && iss_addr != 0) mpend[iss_addr] = 1;
    end
  end

  task automatic test_reset();
    rst = 0; a_valid = 1; a_addr = 4; a_data = 32'h44; w_we = 1; w_addr = 3; w_data = 32'h33;
    q1_addr = 1; q2_addr = 2; q3_addr = 3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      vectors++; if (grf_we !== 1'b0) begin errs++; $display("FAIL reset_we got %0b want 0", grf_we); end
    end
    rst = 1; a_valid = 0; w_we = 0; #1;
    vectors++; if (a_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %0b want 1", a_ready); end
    vectors++; if (q_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %0b want 0", q_stall); end
    vectors++; if (pipe_hold !== 1'b0) begin errs++; $display("FAIL reset_hold got %0b want 0", pipe_hold); end
    vectors++; if (grf_we !== 1'b0) begin errs++; $display("FAIL reset_idle_we got %0b want 0", grf_we); end
    q1_addr = 0; q2_addr = 0; q3_addr = 0;
  endtask

  task automatic test_solo_async();
    @(negedge clk); iss_valid = 1; iss_addr = 5;
    @(negedge clk); iss_valid = 0; q1_addr = 5; #1;
    vectors++; if (q_stall !== 1'b1) begin errs++; $display("FAIL solo_pending got %0b want 1", q_stall); end
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    @(negedge clk); a_valid = 0; #1;
    vectors++; if (grf_we !== 1'b1) begin errs++; $display("FAIL solo_we got %0b want 1", grf_we); end
    vectors++; if (grf_a3 !== 5'd5) begin errs++; $display("FAIL solo_a3 got %0d want 5", grf_a3); end
    vectors++; if (grf_wd !== 32'hDEADBEEF) begin errs++; $display("FAIL solo_wd got %h want deadbeef", grf_wd); end
    vectors++; if (q_stall !== 1'b1) begin errs++; $display("FAIL solo_stall_until_write got %0b want 1", q_stall); end
    @(negedge clk); #1;
    vectors++; if (q_stall !== 1'b0) begin errs++; $display("FAIL solo_cleared got %0b want 0", q_stall); end
    vectors++; if (grf_we !== 1'b0) begin errs++; $display("FAIL solo_idle_we got %0b want 0", grf_we); end
    q1_addr = 0;
  endtask

  task automatic test_contention();
    @(negedge clk); w_we = 1; w_addr = 9; w_data = 32'h9999; a_valid = 1; a_addr = 10; a_data = 32'hC0FFEE;
    @(negedge clk); a_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (grf_we !== 1'b1 || grf_a3 !== 5'd9) begin errs++; $display("FAIL contend_w_grant cyc %0d got we=%0b a3=%0d want we=1 a3=9", i, grf_we, grf_a3); end
      vectors++; if (pipe_hold !== 1'b0) begin errs++; $display("FAIL contend_no_hold cyc %0d got %0b want 0", i, pipe_hold); end
      @(negedge clk);
    end
    #1;
    vectors++; if (pipe_hold !== 1'b1) begin errs++; $display("FAIL contend_hold got %0b want 1", pipe_hold); end
    vectors++; if (grf_we !== 1'b1 || grf_a3 !== 5'd10 || grf_wd !== 32'hC0FFEE) begin errs++; $display("FAIL contend_fifo_write got we=%0b a3=%0d wd=%h want 1/10/c0ffee", grf_we, grf_a3, grf_wd); end
    @(negedge clk); #1;
    vectors++; if (pipe_hold !== 1'b0) begin errs++; $display("FAIL contend_hold_drop got %0b want 0", pipe_hold); end
    vectors++; if (grf_a3 !== 5'd9) begin errs++; $display("FAIL contend_w_resume got %0d want 9", grf_a3); end
    w_we = 0;
  endtask

  task automatic test_full_fifo();
    logic [4:0] got[$];
    bit acc;
    @(negedge clk); w_we = 1; w_addr = 20; w_data = 32'h2020;
    a_valid = 1; a_addr = 11; a_data = 32'hA000 + 11; #1;
    vectors++; if (a_ready !== 1'b1) begin errs++; $display("FAIL full_ready0 got %0b want 1", a_ready); end
    @(negedge clk); a_addr = 12; a_data = 32'hA000 + 12; #1;
    vectors++; if (a_ready !== 1'b1) begin errs++; $display("FAIL full_ready1 got %0b want 1", a_ready); end
    @(negedge clk); a_addr = 13; a_data = 32'hA000 + 13; #1;
    vectors++; if (a_ready !== 1'b0) begin errs++; $display("FAIL full_ready2 got %0b want 0", a_ready); end
    for (int i = 0; i < 40 && got.size() < 3; i++) begin
      if (grf_we && grf_a3 != 5'd20) begin
        got.push_back(grf_a3);
        vectors++; if (grf_wd !== 32'hA000 + grf_a3) begin errs++; $display("FAIL full_pop_data got %h want %h", grf_wd, 32'hA000 + grf_a3); end
      end
      acc = a_ready && a_valid;
      @(negedge clk);
      if (acc) a_valid = 0;
      #1;
    end
    vectors++; if (got.size() !== 3) begin errs++; $display("FAIL full_pop_count got %0d want 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 5'(11 + i)) begin errs++; $display("FAIL full_order idx %0d got %0d want %0d", i, got[i], 11 + i); end
    end
    w_we = 0; a_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero();
    @(negedge clk); iss_valid = 1; iss_addr = 6;
    @(negedge clk); iss_addr = 0; a_valid = 1; a_addr = 0; a_data = 32'h0BAD;
    @(negedge clk); iss_valid = 0; a_valid = 0; q1_addr = 6; #1;
    vectors++; if (grf_we !== 1'b0) begin errs++; $display("FAIL zero_we got %0b want 0", grf_we); end
    vectors++; if (q_stall !== 1'b1) begin errs++; $display("FAIL zero_pend6 got %0b want 1", q_stall); end
    q1_addr = 0; #1;
    vectors++; if (q_stall !== 1'b0) begin errs++; $display("FAIL zero_no_stall got %0b want 0", q_stall); end
    @(negedge clk); a_valid = 1; a_addr = 6; a_data = 32'h6666; q3_addr = 6; #1;
    vectors++; if (q_stall !== 1'b1) begin errs++; $display("FAIL zero_pend_unchanged got %0b want 1", q_stall); end
    @(negedge clk); a_valid = 0; #1;
    vectors++; if (grf_we !== 1'b1 || grf_a3 !== 5'd6 || grf_wd !== 32'h6666) begin errs++; $display("FAIL zero_next_pop got we=%0b a3=%0d wd=%h want 1/6/6666", grf_we, grf_a3, grf_wd); end
    @(negedge clk); #1;
    vectors++; if (q_stall !== 1'b0) begin errs++; $display("FAIL zero_cleared got %0b want 0", q_stall); end
    q3_addr = 0;
  endtask

  task automatic test_set_clear();
    @(negedge clk); iss_valid = 1; iss_addr = 7;
    @(negedge clk); iss_valid = 0; a_valid = 1; a_addr = 7; a_data = 32'h7777;
    @(negedge clk); a_valid = 0; iss_valid = 1; iss_addr = 7; #1;
    vectors++; if (grf_we !== 1'b1 || grf_a3 !== 5'd7) begin errs++; $display("FAIL sc_pop got we=%0b a3=%0d want 1/7", grf_we, grf_a3); end
    @(negedge clk); iss_valid = 0; q2_addr = 7; #1;
    vectors++; if (q_stall !== 1'b1) begin errs++; $display("FAIL sc_set_wins got %0b want 1", q_stall); end
    a_valid = 1; a_addr = 7; a_data = 32'h7778;
    @(negedge clk); a_valid = 0;
    @(negedge clk); #1;
    vectors++; if (q_stall !== 1'b0) begin errs++; $display("FAIL sc_final_clear got %0b want 0", q_stall); end
    q2_addr = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 99) != 0;
      if (!pipe_hold || !rst) begin
        w_we = $urandom_range(0, 1);
        w_addr = 5'($urandom);
        w_data = $urandom;
      end
      if (!(a_valid && !a_ready)) begin
        a_valid = $urandom_range(0, 9) < 4;
        a_addr = $urandom_range(0, 7);
        a_data = $urandom;
      end
      iss_valid = $urandom_range(0, 4) == 0;
      iss_addr = $urandom_range(0, 7);
      q1_addr = $urandom_range(0, 7);
      q2_addr = $urandom_range(0, 7);
      q3_addr = $urandom_range(0, 7);
      #1;
      predict();
      vectors++; if (grf_we !== e_we) begin errs++; $display("FAIL rnd_we cyc %0d got %0b want %0b", i, grf_we, e_we); end
      if (e_we) begin
        vectors++; if (grf_a3 !== e_a3 || grf_wd !== e_wd) begin errs++; $display("FAIL rnd_write cyc %0d got %0d/%h want %0d/%h", i, grf_a3, grf_wd, e_a3, e_wd); end
      end
      vectors++; if (a_ready !== e_ready) begin errs++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", i, a_ready, e_ready); end
      vectors++; if (pipe_hold !== mhold) begin errs++; $display("FAIL rnd_hold cyc %0d got %0b want %0b", i, pipe_hold, mhold); end
      vectors++; if (q_stall !== e_stall) begin errs++; $display("FAIL rnd_stall cyc %0d got %0b want %0b", i, q_stall, e_stall); end
    end
    @(negedge clk); rst = 1; w_we = 0; a_valid = 0; iss_valid = 0;
  endtask

  initial begin
    test_reset();
    test_solo_async();
    test_contention();
    test_full_fifo();
    test_zero();
    test_set_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
- Shares the single register-file write port (A3/WE/WD3) between the in-order W-stage writeback and a multi-cycle asynchronous result source (MDU / long-latency unit).
- Buffers async results in a small FIFO, guarantees forward progress with a starvation counter, and keeps a 32-entry pending-write scoreboard the D-stage queries for RAW/WAW stalls.
- Sits between the W stage, the async unit and the GRF; the GRF is driven only through this block.

Parameters:
- FIFO_DEPTH, 2, async result buffer entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be denied before forcing a pipeline hold (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- w_we  in  1  W-stage write request
- w_addr  in  5  W-stage destination register
- w_data  in  32  W-stage write data
- a_valid  in  1  async result valid
- a_addr  in  5  async result destination
- a_data  in  32  async result data
- a_ready  out  1  FIFO can accept (registered, = !full)
- iss_valid  in  1  async op issued this cycle (marks destination pending)
- iss_addr  in  5  destination of issued op
- q1_addr  in  5  D-stage source rs
- q2_addr  in  5  D-stage source rt
- q3_addr  in  5  D-stage destination (WAW check)
- q_stall  out  1  any queried address pending (combinational)
- pipe_hold  out  1  starvation hold request to pipeline (registered)
- grf_we  out  1  GRF WE
- grf_a3  out  5  GRF A3
- grf_wd  out  32  GRF WD3

Behaviour:
- Reset (rst==0 at edge): FIFO empty, pending bitmap = 0, starve counter = 0, pipe_hold = 0, a_ready = 1; grf_we = 0 in every cycle in which rst==0.
- Arbitration, per cycle (combinational grant, write lands on the next clk edge):
  - pipe_hold==0 and w_we==1 -> W wins: grf_* = w_*.
  - Otherwise, if FIFO non-empty -> pop head: grf_* = head.
  - Otherwise grf_we = 0.
  - pipe_hold==1 -> FIFO wins unconditionally. Pipeline contract: while pipe_hold==1 the W stage is frozen and re-presents the same write next cycle; the W write is not lost.
- Address 0: grf_we forced 0 when the granted address is 0; a FIFO entry to $0 is still popped.
- FIFO: push when a_valid & a_ready. Push and pop in the same cycle is allowed when full, but a_ready stays 0 that cycle (registered). a_valid while !a_ready: ignored, source must hold. Pointers wrap mod FIFO_DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and not popped; clears on pop or when empty.
  - When counter == STARVE_LIMIT-1 and incrementing, pipe_hold goes 1 next cycle.
  - pipe_hold drops the cycle after the pop it forced.
  - Counter saturates; never wraps.
- Scoreboard (pend[31:0], pend[0] always 0):
  - Set: iss_valid & iss_addr!=0 sets pend[iss_addr] at the edge.
  - Clear: a FIFO pop clears pend[head.addr] at the same edge the GRF is written.
  - Set and clear of the same address in one cycle: set wins.
- q_stall: (pend[q1]|pend[q2]|pend[q3]); addresses of 0 contribute 0. Pending-clear and GRF write share an edge, so the next-cycle read of the GRF returns the new value; no bypass is required.
- W writes never touch pend; WAW is prevented by the q3 stall.
- Latency: async result accepted at edge N is written at edge N+1 at the earliest.

Decomposition:
- Shared package: REG_W=5, DATA_W=32, NUM_REGS=32, and a wb_req struct {we, addr, data} used by the W-stage and FIFO entries.
- One natural sub-module: grf_wb_fifo (parametric FIFO with registered full/empty). Arbiter, starve counter and scoreboard stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with a_valid=1 and w_we=1 -> grf_we=0, a_ready=1, q_stall=0, pipe_hold=0 after release.
- Solo async: iss (addr 5), then a_valid (addr 5, 0xDEADBEEF) -> q1=5 stalls until the write edge; grf_a3=5 and grf_wd=0xDEADBEEF one cycle after accept; q_stall=0 the next cycle.
- Contention: w_we=1 every cycle plus one async push -> W granted for 4 cycles, pipe_hold=1 on the 5th, FIFO write on the 5th, pipe_hold=0 on the 6th.
- Full FIFO: 3 back-to-back a_valid with no drain (w_we busy) -> a_ready=0 after 2 accepts; the third is held and accepted after a pop.
- $0 handling: async result to addr 0 -> popped, grf_we=0, pend unchanged; iss_addr=0 never stalls.
- Same-cycle set/clear: pop of addr 7 with iss_valid addr 7 in the same cycle -> pend[7] remains 1, q1=7 still stalls.
